// File: rtl/vz_saver_pkg.sv
// Shared constants and state type for the VZ file saver.
package vz_pkg;
    localparam logic [7:0]  VZ_BASIC          = 8'hF0;
    localparam logic [7:0]  VZ_MCODE          = 8'hF1;
    localparam int          HDR_LEN           = 24;
    localparam logic [7:0]  VZ_MAGIC0         = 8'h56;  // 'V'
    localparam logic [7:0]  VZ_MAGIC1         = 8'h5A;  // 'Z'
    localparam logic [7:0]  VZ_MAGIC2         = 8'h46;  // 'F'
    localparam logic [7:0]  VZ_MAGIC3         = 8'h30;  // '0'
    localparam logic [15:0] ADDR_BAS_START_LO = 16'h78A4;
    localparam logic [15:0] ADDR_BAS_END_LO   = 16'h78F9;
    localparam logic [15:0] MAX_BODY_LEN      = 16'hFFE7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PTR,
        S_CHECK,
        S_HDR,
        S_BODY,
        S_FIN
    } vz_save_state_t;
endpackage

// File: rtl/vz_saver_if.sv
// Control, RAM read port and byte-stream sink of the VZ saver.
interface vz_saver_if;
    logic         save_go;
    logic         save_abort;
    logic         mode_mcode;
    logic [15:0]  mc_start;
    logic [15:0]  mc_end;
    logic [127:0] file_name;
    logic [15:0]  mem_addr;
    logic         mem_rd;
    logic [7:0]   mem_data;
    logic [7:0]   out_data;
    logic [15:0]  out_addr;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic         busy;
    logic         done;
    logic         error;

    modport master (
        output save_go, save_abort, mode_mcode, mc_start, mc_end, file_name,
               mem_data, out_ready,
        input  mem_addr, mem_rd, out_data, out_addr, out_valid, out_last,
               busy, done, error
    );

    modport slave (
        input  save_go, save_abort, mode_mcode, mc_start, mc_end, file_name,
               mem_data, out_ready,
        output mem_addr, mem_rd, out_data, out_addr, out_valid, out_last,
               busy, done, error
    );
endinterface

// File: rtl/vz_saver_header_gen.sv
// Combinational selector for the 24-byte .VZ header: magic, name, pad, type, start address.
module vz_header_gen
    import vz_pkg::*;
(
    input  logic [4:0]   i_offset,
    input  logic [127:0] i_name,
    input  logic [7:0]   i_type,
    input  logic [15:0]  i_start,
    output logic [7:0]   o_byte
);
    logic [4:0] w_name_idx;

    assign w_name_idx = i_offset - 5'd4;

    always_comb begin
        o_byte = 8'h00;
        case (i_offset)
            5'd0:    o_byte = VZ_MAGIC0;
            5'd1:    o_byte = VZ_MAGIC1;
            5'd2:    o_byte = VZ_MAGIC2;
            5'd3:    o_byte = VZ_MAGIC3;
            5'd21:   o_byte = i_type;
            5'd22:   o_byte = i_start[7:0];
            5'd23:   o_byte = i_start[15:8];
            default: begin
                if (i_offset >= 5'd4 && i_offset <= 5'd19)
                    o_byte = i_name[{w_name_idx[3:0], 3'b000} +: 8];
            end
        endcase
    end
endmodule

// File: rtl/vz_saver.sv
// Reads a program image from RAM and streams it out as a .VZ file, one byte at a time.
// States: IDLE wait | PTR read BASIC pointers | CHECK range | HDR header | BODY image | FIN done
module vz_saver
    import vz_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic         I_CLK,
    input  logic         I_RST,
    vz_saver_if.slave    bus
);
    localparam int LAT_W = $clog2(MEM_LAT + 1);

    vz_save_state_t r_state, w_next;

    logic             r_mode;
    logic [127:0]     r_name;
    logic [15:0]      r_start, r_end, r_cur_addr, r_off;
    logic [1:0]       r_ptr_idx;
    logic             r_inflight;
    logic [LAT_W-1:0] r_lat;
    logic [7:0]       r_od;
    logic [15:0]      r_oa;
    logic             r_ov, r_olast, r_err;

    logic        w_rd, w_cap, w_acc, w_go, w_bad;
    logic [15:0] w_body_len, w_ptr_addr;
    logic [7:0]  w_type, w_hdr_byte;

    assign w_go       = bus.save_go && !bus.save_abort;
    assign w_cap      = r_inflight && (r_lat == LAT_W'(1));
    assign w_acc      = r_ov && bus.out_ready;
    assign w_body_len = r_end - r_start;
    assign w_bad      = (r_end < r_start) || (w_body_len > MAX_BODY_LEN);
    assign w_type     = r_mode ? VZ_MCODE : VZ_BASIC;

    always_comb begin
        case (r_ptr_idx)
            2'd0:    w_ptr_addr = ADDR_BAS_START_LO;
            2'd1:    w_ptr_addr = ADDR_BAS_START_LO + 16'd1;
            2'd2:    w_ptr_addr = ADDR_BAS_END_LO;
            default: w_ptr_addr = ADDR_BAS_END_LO + 16'd1;
        endcase
    end

    vz_header_gen u_hdr (
        .i_offset (r_off[4:0]),
        .i_name   (r_name),
        .i_type   (w_type),
        .i_start  (r_start),
        .o_byte   (w_hdr_byte)
    );

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_go) w_next = bus.mode_mcode ? S_CHECK : S_PTR;
            S_PTR:   if (w_cap && r_ptr_idx == 2'd3) w_next = S_CHECK;
            S_CHECK: w_next = w_bad ? S_IDLE : S_HDR;
            S_HDR:   if (w_acc && r_oa == 16'(HDR_LEN - 1)) w_next = r_olast ? S_FIN : S_BODY;
            S_BODY:  if (w_acc && r_olast) w_next = S_FIN;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (bus.save_abort) w_next = S_IDLE;
    end

    // Reads are strobed combinationally; BODY waits for the held byte to drain first.
    always_comb begin
        w_rd         = 1'b0;
        bus.mem_addr = 16'h0000;
        case (r_state)
            S_PTR:   w_rd = !r_inflight;
            S_BODY:  w_rd = !r_inflight && !r_ov;
            default: w_rd = 1'b0;
        endcase
        if (w_rd) bus.mem_addr = (r_state == S_PTR) ? w_ptr_addr : r_cur_addr;
        bus.busy = (r_state != S_IDLE) && (r_state != S_FIN);
        bus.done = (r_state == S_FIN);
    end

    assign bus.mem_rd    = w_rd;
    assign bus.out_data  = r_od;
    assign bus.out_addr  = r_oa;
    assign bus.out_valid = r_ov;
    assign bus.out_last  = r_olast;
    assign bus.error     = r_err;

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            r_mode     <= 1'b0;
            r_name     <= '0;
            r_start    <= '0;
            r_end      <= '0;
            r_cur_addr <= '0;
            r_off      <= '0;
            r_ptr_idx  <= '0;
            r_inflight <= 1'b0;
            r_lat      <= '0;
            r_od       <= '0;
            r_oa       <= '0;
            r_ov       <= 1'b0;
            r_olast    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (bus.save_abort) begin
                r_ov       <= 1'b0;
                r_olast    <= 1'b0;
                r_inflight <= 1'b0;
            end else begin
                if (w_rd) begin
                    r_inflight <= 1'b1;
                    r_lat      <= LAT_W'(MEM_LAT);
                end else if (w_cap) begin
                    r_inflight <= 1'b0;
                end else if (r_inflight) begin
                    r_lat <= r_lat - LAT_W'(1);
                end

                case (r_state)
                    S_IDLE: begin
                        if (w_go) begin
                            r_mode     <= bus.mode_mcode;
                            r_name     <= bus.file_name;
                            r_start    <= bus.mc_start;
                            r_end      <= bus.mc_end;
                            r_off      <= '0;
                            r_ptr_idx  <= '0;
                            r_cur_addr <= '0;
                        end
                    end
                    S_PTR: begin
                        if (w_cap) begin
                            case (r_ptr_idx)
                                2'd0:    r_start[7:0]  <= bus.mem_data;
                                2'd1:    r_start[15:8] <= bus.mem_data;
                                2'd2:    r_end[7:0]    <= bus.mem_data;
                                default: r_end[15:8]   <= bus.mem_data;
                            endcase
                            r_ptr_idx <= r_ptr_idx + 2'd1;
                        end
                    end
                    S_CHECK: begin
                        r_cur_addr <= r_start;
                        r_err      <= w_bad;
                    end
                    S_HDR: begin
                        if ((!r_ov || w_acc) && r_off < 16'(HDR_LEN)) begin
                            r_od    <= w_hdr_byte;
                            r_oa    <= r_off;
                            r_ov    <= 1'b1;
                            r_olast <= (r_off == 16'(HDR_LEN - 1)) && (r_end == r_start);
                            r_off   <= r_off + 16'd1;
                        end else if (w_acc) begin
                            r_ov    <= 1'b0;
                            r_olast <= 1'b0;
                        end
                    end
                    S_BODY: begin
                        if (w_cap) begin
                            r_od       <= bus.mem_data;
                            r_oa       <= r_off;
                            r_ov       <= 1'b1;
                            r_olast    <= (r_cur_addr + 16'd1 == r_end);
                            r_off      <= r_off + 16'd1;
                            r_cur_addr <= r_cur_addr + 16'd1;
                        end else if (w_acc) begin
                            r_ov    <= 1'b0;
                            r_olast <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_vz_saver.sv
// Directed bench: two saver instances (MEM_LAT 1 and 3) driven in lockstep from shared stimulus.
module tb_vz_saver;
    logic         clk = 1'b0;
    logic         rst;
    logic         save_go, mode_mcode, rnd_ready, mon_clr;
    logic         out_ready = 1'b1;
    logic [1:0]   abort_v;
    logic [15:0]  mc_start, mc_end;
    logic [127:0] file_name;
    logic [7:0]   mem [0:65535];
    string        name_s = "VZSAVER_TEST_01!";

    int           n_cmp = 0, n_fail = 0;
    logic [7:0]   exp_b [0:63];
    int           exp_n;

    logic [1:0]   t_valid, t_busy, t_done, t_err, t_rd, t_last;
    logic [7:0]   t_data  [2];
    logic [15:0]  t_oaddr [2];
    logic [15:0]  t_maddr [2];
    int           m_n [2], m_vseen [2], m_done [2], m_err [2], m_rd [2], m_viol [2];
    int           m_last_cyc [2], m_done_cyc [2], m_bad_busy [2];
    logic [24:0]  m_cap [2][64];

    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        #2;
        out_ready = rnd_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
    end

    vz_saver_if bus [2] ();

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [7:0]  pipe [0:2];
        logic [24:0] cap [64];
        int          n, vseen, done_c, err_c, rd_c, viol, pend, cyc, last_cyc, done_cyc, bad_busy, v;
        logic        hold;
        logic [7:0]  hold_d;
        logic [15:0] hold_a;

        assign bus[g].save_go    = save_go;
        assign bus[g].save_abort = abort_v[g];
        assign bus[g].mode_mcode = mode_mcode;
        assign bus[g].mc_start   = mc_start;
        assign bus[g].mc_end     = mc_end;
        assign bus[g].file_name  = file_name;
        assign bus[g].out_ready  = out_ready;
        assign bus[g].mem_data   = pipe[LAT-1];

        assign t_valid[g] = bus[g].out_valid;
        assign t_busy[g]  = bus[g].busy;
        assign t_done[g]  = bus[g].done;
        assign t_err[g]   = bus[g].error;
        assign t_rd[g]    = bus[g].mem_rd;
        assign t_last[g]  = bus[g].out_last;
        assign t_data[g]  = bus[g].out_data;
        assign t_oaddr[g] = bus[g].out_addr;
        assign t_maddr[g] = bus[g].mem_addr;
        assign m_n[g] = n;
        assign m_vseen[g] = vseen;
        assign m_done[g] = done_c;
        assign m_err[g] = err_c;
        assign m_rd[g] = rd_c;
        assign m_viol[g] = viol;
        assign m_last_cyc[g] = last_cyc;
        assign m_done_cyc[g] = done_cyc;
        assign m_bad_busy[g] = bad_busy;
        assign m_cap[g] = cap;

        vz_saver #(.MEM_LAT(LAT)) u_dut (
            .I_CLK (clk),
            .I_RST (rst),
            .bus   (bus[g])
        );

        // RAM model: data appears exactly LAT cycles after the strobe, garbage otherwise.
        always @(posedge clk) begin
            pipe[0] <= bus[g].mem_rd ? mem[bus[g].mem_addr] : 8'hEE;
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end

        always @(negedge clk) begin
            cyc <= cyc + 1;
            if (mon_clr) begin
                n <= 0; vseen <= 0; done_c <= 0; err_c <= 0; rd_c <= 0; viol <= 0;
                pend <= 0; hold <= 1'b0; bad_busy <= 0; last_cyc <= 0; done_cyc <= 0;
            end else begin
                v = 0;
                if (bus[g].out_valid && out_ready) begin
                    if (n < 64) cap[n] <= {bus[g].out_data, bus[g].out_addr, bus[g].out_last};
                    n <= n + 1;
                    if (bus[g].out_last) last_cyc <= cyc;
                end
                if (bus[g].out_valid) vseen <= vseen + 1;
                if (bus[g].done) begin
                    done_c   <= done_c + 1;
                    done_cyc <= cyc;
                    if (bus[g].busy) bad_busy <= 1;
                end
                if (bus[g].error) err_c <= err_c + 1;
                if (hold && (!bus[g].out_valid || bus[g].out_data !== hold_d ||
                             bus[g].out_addr !== hold_a)) v = v + 1;
                hold   <= bus[g].out_valid && !out_ready;
                hold_d <= bus[g].out_data;
                hold_a <= bus[g].out_addr;
                if (bus[g].mem_rd) begin
                    rd_c <= rd_c + 1;
                    pend <= LAT;
                    if (pend != 0 || (bus[g].out_valid && !out_ready)) v = v + 1;
                end else if (pend != 0) begin
                    pend <= pend - 1;
                end
                viol <= viol + v;
            end
        end
    end

    task automatic clear_mon();
        @(posedge clk); #1;
        mon_clr = 1'b1;
        @(posedge clk); #1;
        mon_clr = 1'b0;
    endtask

    task automatic start_save(input logic mcode, input logic [15:0] s, input logic [15:0] e);
        mode_mcode = mcode;
        mc_start   = s;
        mc_end     = e;
        save_go    = 1'b1;
        @(posedge clk); #1;
        save_go    = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int k;
        k = 0;
        while (k < 600 && !((m_done[0] + m_err[0]) > 0 && (m_done[1] + m_err[1]) > 0)) begin
            @(posedge clk); #1;
            k++;
        end
        n_cmp++;
        if (k >= 600) begin
            n_fail++;
            $display("FAIL %s timeout: got no done/error after %0d cycles, want one", tag, k);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic build_exp(input logic [7:0] typ, input logic [15:0] s, input int len);
        exp_b[0] = 8'h56; exp_b[1] = 8'h5A; exp_b[2] = 8'h46; exp_b[3] = 8'h30;
        for (int i = 0; i < 16; i++) exp_b[4+i] = name_s[i];
        exp_b[20] = 8'h00;
        exp_b[21] = typ;
        exp_b[22] = s[7:0];
        exp_b[23] = s[15:8];
        for (int i = 0; i < len; i++) exp_b[24+i] = mem[s + 16'(i)];
        exp_n = 24 + len;
    endtask

    task automatic check_stream(input string tag);
        logic [24:0] want;
        for (int g = 0; g < 2; g++) begin
            n_cmp++;
            if (m_n[g] !== exp_n) begin
                n_fail++;
                $display("FAIL %s dut%0d byte_count got %0d want %0d", tag, g, m_n[g], exp_n);
            end
            for (int i = 0; i < exp_n; i++) begin
                want = {exp_b[i], 16'(i), (i == exp_n - 1)};
                n_cmp++;
                if (m_cap[g][i] !== want) begin
                    n_fail++;
                    $display("FAIL %s dut%0d byte%0d {data,addr,last} got %h want %h",
                             tag, g, i, m_cap[g][i], want);
                end
            end
            n_cmp++;
            if (m_done[g] !== 1 || m_err[g] !== 0) begin
                n_fail++;
                $display("FAIL %s dut%0d done/error got %0d/%0d want 1/0", tag, g, m_done[g], m_err[g]);
            end
            n_cmp++;
            if (m_viol[g] !== 0) begin
                n_fail++;
                $display("FAIL %s dut%0d handshake_violations got %0d want 0", tag, g, m_viol[g]);
            end
            n_cmp++;
            if (m_done_cyc[g] - m_last_cyc[g] !== 1 || m_bad_busy[g] !== 0) begin
                n_fail++;
                $display("FAIL %s dut%0d done_delay got %0d busy_at_done %0d want 1/0",
                         tag, g, m_done_cyc[g] - m_last_cyc[g], m_bad_busy[g]);
            end
        end
    endtask

    task automatic check_byte(input string tag, input int idx, input logic [7:0] want);
        for (int g = 0; g < 2; g++) begin
            n_cmp++;
            if (m_cap[g][idx][24:17] !== want) begin
                n_fail++;
                $display("FAIL %s dut%0d hdr[%0d] got %h want %h", tag, g, idx, m_cap[g][idx][24:17], want);
            end
        end
    endtask

    task automatic check_rd(input string tag, input int want);
        for (int g = 0; g < 2; g++) begin
            n_cmp++;
            if (m_rd[g] !== want) begin
                n_fail++;
                $display("FAIL %s dut%0d mem_rd_count got %0d want %0d", tag, g, m_rd[g], want);
            end
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        for (int g = 0; g < 2; g++) begin
            n_cmp++;
            if ({t_valid[g], t_busy[g], t_done[g], t_err[g], t_rd[g], t_last[g],
                 t_data[g], t_oaddr[g], t_maddr[g]} !== 46'h0) begin
                n_fail++;
                $display("FAIL %s dut%0d outputs got v%b b%b d%b e%b r%b l%b data %h oaddr %h maddr %h want all 0",
                         tag, g, t_valid[g], t_busy[g], t_done[g], t_err[g], t_rd[g], t_last[g],
                         t_data[g], t_oaddr[g], t_maddr[g]);
            end
        end
    endtask

    task automatic test_reset();
        check_outputs_zero("reset_held");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset_released");
    endtask

    task automatic test_mcode();
        mem[16'h8000] = 8'h11; mem[16'h8001] = 8'h22; mem[16'h8002] = 8'h33;
        clear_mon();
        start_save(1'b1, 16'h8000, 16'h8003);
        wait_end("mcode");
        build_exp(8'hF1, 16'h8000, 3);
        check_stream("mcode");
        check_byte("mcode", 21, 8'hF1);
        check_byte("mcode", 22, 8'h00);
        check_byte("mcode", 23, 8'h80);
        check_byte("mcode", 26, 8'h33);
        check_rd("mcode", 3);
    endtask

    task automatic test_basic();
        mem[16'h78A4] = 8'hE9; mem[16'h78A5] = 8'h7A;
        mem[16'h78F9] = 8'hEC; mem[16'h78FA] = 8'h7A;
        mem[16'h7AE9] = 8'hA1; mem[16'h7AEA] = 8'hB2; mem[16'h7AEB] = 8'hC3;
        clear_mon();
        start_save(1'b0, 16'h1234, 16'h5678);
        wait_end("basic");
        build_exp(8'hF0, 16'h7AE9, 3);
        check_stream("basic");
        check_byte("basic", 21, 8'hF0);
        check_byte("basic", 22, 8'hE9);
        check_byte("basic", 23, 8'h7A);
        check_byte("basic", 25, 8'hB2);
        check_rd("basic", 7);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) mem[16'hA000 + 16'(i)] = 8'h5A ^ 8'(i * 37);
        rnd_ready = 1'b1;
        clear_mon();
        start_save(1'b1, 16'hA000, 16'hA005);
        repeat (12) @(posedge clk);
        #1;
        start_save(1'b0, 16'h1111, 16'h2222);
        wait_end("backpressure");
        rnd_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        build_exp(8'hF1, 16'hA000, 5);
        check_stream("backpressure");
        check_rd("backpressure", 5);
    endtask

    task automatic test_error_and_empty();
        string tags [2];
        logic [15:0] es [2], ee [2];
        tags[0] = "err_end_lt_start"; es[0] = 16'h9000; ee[0] = 16'h8FFF;
        tags[1] = "err_too_long";     es[1] = 16'h0000; ee[1] = 16'hFFE8;
        for (int t = 0; t < 2; t++) begin
            clear_mon();
            start_save(1'b1, es[t], ee[t]);
            wait_end(tags[t]);
            for (int g = 0; g < 2; g++) begin
                n_cmp++;
                if (m_err[g] !== 1 || m_done[g] !== 0 || m_vseen[g] !== 0 || t_busy[g] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s dut%0d err/done/valid_cycles/busy got %0d/%0d/%0d/%b want 1/0/0/0",
                             tags[t], g, m_err[g], m_done[g], m_vseen[g], t_busy[g]);
                end
            end
        end
        clear_mon();
        start_save(1'b1, 16'h9000, 16'h9000);
        wait_end("empty_9000");
        build_exp(8'hF1, 16'h9000, 0);
        check_stream("empty_9000");
        check_rd("empty_9000", 0);
        clear_mon();
        start_save(1'b1, 16'hFFFF, 16'hFFFF);
        wait_end("empty_ffff");
        build_exp(8'hF1, 16'hFFFF, 0);
        check_stream("empty_ffff");
        check_rd("empty_ffff", 0);
    endtask

    task automatic test_abort();
        int k;
        clear_mon();
        start_save(1'b1, 16'h8000, 16'h8003);
        for (int g = 0; g < 2; g++) begin
            k = 0;
            while (k < 200 && !(t_valid[g] && t_oaddr[g] == 16'd25)) begin
                @(posedge clk); #1;
                k++;
            end
            n_cmp++;
            if (k >= 200) begin
                n_fail++;
                $display("FAIL abort_reach25 dut%0d timeout: offset 25 not seen, want it", g);
            end
            abort_v[g] = 1'b1;
            @(posedge clk); #1;
            abort_v[g] = 1'b0;
            n_cmp++;
            if (t_busy[g] !== 1'b0 || t_valid[g] !== 1'b0 || t_rd[g] !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_drop dut%0d busy/valid/rd got %b/%b/%b want 0/0/0",
                         g, t_busy[g], t_valid[g], t_rd[g]);
            end
        end
        repeat (10) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            n_cmp++;
            if (m_done[g] !== 0 || m_err[g] !== 0 || t_valid[g] !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_quiet dut%0d done/err/valid got %0d/%0d/%b want 0/0/0",
                         g, m_done[g], m_err[g], t_valid[g]);
            end
        end
        clear_mon();
        start_save(1'b1, 16'h8000, 16'h8003);
        wait_end("after_abort");
        build_exp(8'hF1, 16'h8000, 3);
        check_stream("after_abort");
    endtask

    task automatic test_reset_mid();
        int k;
        clear_mon();
        start_save(1'b1, 16'h8000, 16'h8003);
        k = 0;
        while (k < 200 && !(t_valid[0] && t_oaddr[0] >= 16'd24)) begin
            @(posedge clk); #1;
            k++;
        end
        n_cmp++;
        if (k >= 200) begin
            n_fail++;
            $display("FAIL reset_mid_reach_body timeout: body not reached, want it");
        end
        #2;
        rst = 1'b1;
        #1;
        check_outputs_zero("reset_mid_async");
        #3;
        rst = 1'b0;
        @(posedge clk); #1;
        for (int g = 0; g < 2; g++) begin
            n_cmp++;
            if (t_busy[g] !== 1'b0 || t_valid[g] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_idle dut%0d busy/valid got %b/%b want 0/0", g, t_busy[g], t_valid[g]);
            end
        end
        clear_mon();
        start_save(1'b1, 16'h9000, 16'h9000);
        wait_end("post_reset");
        build_exp(8'hF1, 16'h9000, 0);
        check_stream("post_reset");
    endtask

    initial begin
        rst        = 1'b1;
        save_go    = 1'b0;
        abort_v    = 2'b00;
        mode_mcode = 1'b0;
        mc_start   = 16'h0000;
        mc_end     = 16'h0000;
        rnd_ready  = 1'b0;
        mon_clr    = 1'b1;
        for (int i = 0; i < 16; i++) file_name[i*8 +: 8] = name_s[i];
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        mon_clr = 1'b0;
        test_reset();
        test_mcode();
        test_basic();
        test_backpressure();
        test_error_and_empty();
        test_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
